cyq_cmp_filter: RTL and testbench
=================================

# cyq_cmp_filter

Registered, debounced consumer of the 3-bit magnitude-compare result (Q[2]=A>B, Q[1]=A==B, Q[0]=A<B) produced by the combinational 4-bit code-convert-and-compare path. It synchronises the raw result and accepts a new value only after it has held stable for STABLE cycles. It publishes the accepted one-hot result with a single-cycle VALID strobe and flags non-one-hot results. It keeps saturating occurrence counters per outcome for the board display/readout stage.

## Interface
- STABLE, 4, cycles a synchronised value must hold before commit; legal range 2..255
- CW, 8, width of each occurrence counter
- CLK  in  1  system clock, rising edge
- RST  in  1  reset; one clock; reset is asynchronous and active-high
- Q  in  3  raw compare result from comparator, asynchronous to CLK
- CLR  in  1  synchronous clear of counters and ERR
- RES  out  3  last committed one-hot result
- VALID  out  1  one-cycle strobe on the cycle RES takes a new value
- ERR  out  1  last stable value was not one-hot
- GT_CNT  out  CW  commits of 3'b100
- EQ_CNT  out  CW  commits of 3'b010
- LT_CNT  out  CW  commits of 3'b001

## Operation
- Front end: two-flop synchroniser s1→s2 on Q; see Configuration.
- Internal: cand[2:0] (candidate), cnt (0..STABLE-1), state ∈ {SETTLE, LOCKED}.
- Reset values: RES=000, VALID=0, ERR=0, all counters 0, s1=s2=cand=000, cnt=0, state=SETTLE.
- Any state, s2≠cand: cand←s2, cnt←0, state←SETTLE. This has priority over everything below.
- SETTLE, s2==cand, cnt<STABLE-1: cnt←cnt+1.
- SETTLE, s2==cand, cnt==STABLE-1: commit, state←LOCKED.
- Commit, cand one-hot and (cand≠RES or ERR=1): RES←cand, VALID=1 for one cycle, ERR←0, and the matching counter increments.
- Commit, cand one-hot and cand==RES and ERR=0: silent. No VALID, no count. A glitch shorter than STABLE that returns to the old value is invisible.
- Commit, cand not one-hot (000, 011, 101, 110, 111): ERR←1. RES, counters and VALID are unchanged.
- LOCKED, s2==cand: hold. No further commits until the value changes.
- Counters saturate at 2^CW-1. They never wrap.
- CLR=1: all counters←0 and ERR←0 on that edge.
- CLR coinciding with a commit: counters and ERR clear (CLR wins). RES still updates and VALID still pulses. If the commit is non-one-hot, ERR←1 (the commit wins for ERR).
- RST asserted mid-settle or mid-commit: all registers return to reset values immediately. No VALID is emitted.

## Timing
- All outputs are registered; there is no combinational path from Q or CLR to any output.
- Latency, counting edges from the first edge that samples a new stable Q:
  - edge 1: s1
  - edge 2: s2
  - edge 3: cand, cnt=0
  - edge STABLE+2: cnt=STABLE-1
  - edge STABLE+3: RES and VALID are visible. With STABLE=4 this is the 7th edge.
- Without CMP_FILTER_SYNC_EN, latency is STABLE+1 edges.
- VALID is high for exactly one cycle per accepted change. Back-to-back VALIDs are impossible: the minimum spacing is STABLE+1 cycles.
- Counters and ERR update on the same edge as VALID/commit.

## Configuration
- CMP_FILTER_SYNC_EN defined: the two-flop synchroniser is present. Q is treated as asynchronous, for pad/switch-driven operation.
- CMP_FILTER_SYNC_EN undefined: s2 is Q directly (combinational feed from a same-clock source). All latencies shrink by 2 edges; all other behaviour is identical.

## Test plan
- Reset, then Q=010 held (sync enabled, STABLE=4): RES=010 and VALID=1 after edge 7 only; EQ_CNT=1, GT_CNT=LT_CNT=0, ERR=0.
- From RES=010: Q=100 for 2 cycles, then back to 010: no VALID, RES stays 010, counters unchanged.
- Q 100 → 001 → 100, each held 10 cycles: three VALID pulses, GT_CNT=2, LT_CNT=1, RES=100.
- Q=110 held 10 cycles after RES=001: ERR=1, RES=001, no VALID. Then Q=001 held: VALID pulses, RES=001, ERR=0, LT_CNT increments.
- CW=2, alternate 100/001 eight times: GT_CNT=LT_CNT=3 (saturated). CLR on the same edge as a commit of 010: counters=0, RES=010, VALID=1.
- RST pulsed at cnt=2 mid-settle: RES=000, VALID=0, counters=0 immediately. A fresh stable Q commits after a full STABLE+3 edges.

Source files
------------

// File: rtl/cyq_cmp_filter.sv
// cyq_cmp_filter: debounced, registered consumer of a 3-bit magnitude-compare
// result (q[2]=A>B, q[1]=A==B, q[0]=A<B).
//
// The raw result is optionally synchronised, must hold stable for STABLE
// cycles before it is committed, and is published on res with a one-cycle
// valid strobe. Non-one-hot stable values raise err instead of updating res.
// Saturating per-outcome counters record every accepted change.
//
// Configuration macro:
//   CMP_FILTER_SYNC_EN  defined   -> two-flop synchroniser on q (async source)
//                       undefined -> q feeds the filter directly (same-clock source)

module cyq_cmp_filter #(
    parameter int STABLE = 4,   // cycles a value must hold before commit, 2..255
    parameter int CW     = 8    // width of each occurrence counter
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    q,
    input  logic          clr,
    output logic [2:0]    res,
    output logic          valid,
    output logic          err,
    output logic [CW-1:0] gt_cnt,
    output logic [CW-1:0] eq_cnt,
    output logic [CW-1:0] lt_cnt
);

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Terminal value of the hold counter; cnt fits 8 bits for STABLE <= 255.
    localparam logic [7:0]    LAST = 8'(STABLE - 1);
    localparam logic [CW-1:0] CMAX = '1;

    logic [2:0] s2;

`ifdef CMP_FILTER_SYNC_EN
    logic [2:0] s1;

    // Two-flop synchroniser: q is asynchronous to clk.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge value of its source; blocking here would collapse s1/s2.
        if (rst) begin
            s1 <= 3'b000;
            s2 <= 3'b000;
        end else begin
            s1 <= q;
            s2 <= s1;
        end
    end
`else
    // Same-clock source: no synchronisation stage.
    assign s2 = q;
`endif

    state_t        state, state_n;
    logic [2:0]    cand,  cand_n;
    logic [7:0]    cnt,   cnt_n;
    logic [2:0]    res_n;
    logic          valid_n;
    logic          err_n;
    logic [CW-1:0] gt_n, eq_n, lt_n;
    logic          commit;
    logic          cand_onehot;

    assign cand_onehot = (cand == 3'b100) || (cand == 3'b010) || (cand == 3'b001);

    // Next-state and output logic for the settle/lock filter and counters.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the
        // branches below can leave one unassigned and infer a latch.
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        commit  = 1'b0;
        res_n   = res;
        valid_n = 1'b0;
        err_n   = err;
        gt_n    = gt_cnt;
        eq_n    = eq_cnt;
        lt_n    = lt_cnt;

        // A changed input restarts the hold window from any state.
        if (s2 != cand) begin
            cand_n  = s2;
            cnt_n   = 8'd0;
            state_n = SETTLE;
        end else if (state == SETTLE) begin
            if (cnt != LAST) begin
                cnt_n = cnt + 8'd1;
            end else begin
                commit  = 1'b1;
                state_n = LOCKED;
            end
        end

        // Clear first, so a non-one-hot commit on the same edge still sets err.
        if (clr) begin
            gt_n  = '0;
            eq_n  = '0;
            lt_n  = '0;
            err_n = 1'b0;
        end

        if (commit) begin
            if (cand_onehot) begin
                // A restatement of the current result is only announced when
                // it recovers from an error; otherwise it stays silent.
                if ((cand != res) || err) begin
                    res_n   = cand;
                    valid_n = 1'b1;
                    err_n   = 1'b0;
                    if (!clr) begin
                        unique case (cand)
                            3'b100:  if (gt_cnt != CMAX) gt_n = gt_cnt + 1'b1;
                            3'b010:  if (eq_cnt != CMAX) eq_n = eq_cnt + 1'b1;
                            3'b001:  if (lt_cnt != CMAX) lt_n = lt_cnt + 1'b1;
                            default: ;
                        endcase
                    end
                end
            end else begin
                err_n = 1'b1;
            end
        end
    end

    // State, candidate and all outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= SETTLE;
            cand   <= 3'b000;
            cnt    <= 8'd0;
            res    <= 3'b000;
            valid  <= 1'b0;
            err    <= 1'b0;
            gt_cnt <= '0;
            eq_cnt <= '0;
            lt_cnt <= '0;
        end else begin
            state  <= state_n;
            cand   <= cand_n;
            cnt    <= cnt_n;
            res    <= res_n;
            valid  <= valid_n;
            err    <= err_n;
            gt_cnt <= gt_n;
            eq_cnt <= eq_n;
            lt_cnt <= lt_n;
        end
    end

endmodule

// File: tb/tb_cyq_cmp_filter.sv
// Self-checking bench for cyq_cmp_filter: directed scenarios with literal
// expectations plus randomized stimulus against a run-length reference model.
// Two instances share stimulus: CW=8 and CW=2 (saturation).

module tb_cyq_cmp_filter;

    localparam int STABLE = 4;
`ifdef CMP_FILTER_SYNC_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif
    // Edge (counted from the first edge sampling a new stable q) of the commit.
    localparam int L = STABLE + 1 + DLY;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] q   = 3'b000;
    logic       clr = 1'b0;

    logic [2:0] res, s_res;
    logic       valid, s_valid, err, s_err;
    logic [7:0] gt8, eq8, lt8;
    logic [1:0] gt2, eq2, lt2;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    cyq_cmp_filter #(.STABLE(STABLE), .CW(8)) u_dut (
        .clk(clk), .rst(rst), .q(q), .clr(clr),
        .res(res), .valid(valid), .err(err),
        .gt_cnt(gt8), .eq_cnt(eq8), .lt_cnt(lt8)
    );

    cyq_cmp_filter #(.STABLE(STABLE), .CW(2)) u_sat (
        .clk(clk), .rst(rst), .q(q), .clr(clr),
        .res(s_res), .valid(s_valid), .err(s_err),
        .gt_cnt(gt2), .eq_cnt(eq2), .lt_cnt(lt2)
    );

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The filter commits a value the moment it has been seen on STABLE+1
    // consecutive edges (reset counts as the first sighting of 000).
    logic [2:0] m_pipe [0:1];
    logic [2:0] m_run_val;
    int         m_run_len;
    logic [2:0] m_res;
    logic       m_valid, m_err;
    int         m_c8 [3];   // 0=gt 1=eq 2=lt
    int         m_c2 [3];

    always @(posedge clk or posedge rst) begin : model
        logic [2:0] v;
        int         rl;
        logic [2:0] rv, r;
        logic       e, vl, cm;
        int         a8 [3];
        int         a2 [3];
        int         idx;
        if (rst) begin
            m_pipe[0] <= 3'b000;
            m_pipe[1] <= 3'b000;
            m_run_val <= 3'b000;
            m_run_len <= 1;
            m_res     <= 3'b000;
            m_valid   <= 1'b0;
            m_err     <= 1'b0;
            m_c8      <= '{0, 0, 0};
            m_c2      <= '{0, 0, 0};
        end else begin
            v  = (DLY == 2) ? m_pipe[1] : q;
            rv = m_run_val;
            rl = m_run_len;
            r  = m_res;
            e  = m_err;
            a8 = m_c8;
            a2 = m_c2;
            cm = 1'b0;
            vl = 1'b0;
            if (v == rv) begin
                if (rl < STABLE + 1) begin
                    rl++;
                    cm = (rl == STABLE + 1);
                end
            end else begin
                rv = v;
                rl = 1;
            end
            if (clr) begin
                a8 = '{0, 0, 0};
                a2 = '{0, 0, 0};
                e  = 1'b0;
            end
            if (cm) begin
                if ($countones(rv) == 1) begin
                    if (rv != r || e) begin
                        r  = rv;
                        vl = 1'b1;
                        e  = 1'b0;
                        idx = rv[2] ? 0 : (rv[1] ? 1 : 2);
                        if (!clr) begin
                            if (a8[idx] < 255) a8[idx]++;
                            if (a2[idx] < 3)   a2[idx]++;
                        end
                    end
                end else begin
                    e = 1'b1;
                end
            end
            m_pipe[1] <= m_pipe[0];
            m_pipe[0] <= q;
            m_run_val <= rv;
            m_run_len <= rl;
            m_res     <= r;
            m_valid   <= vl;
            m_err     <= e;
            m_c8      <= a8;
            m_c2      <= a2;
        end
    end

    // Cycle-by-cycle comparison, sampled well after the active edge.
    always @(posedge clk) begin
        #3;
        check("res",    int'(res),     int'(m_res));
        check("valid",  int'(valid),   int'(m_valid));
        check("err",    int'(err),     int'(m_err));
        check("gt_cnt", int'(gt8),     m_c8[0]);
        check("eq_cnt", int'(eq8),     m_c8[1]);
        check("lt_cnt", int'(lt8),     m_c8[2]);
        check("sat_gt", int'(gt2),     m_c2[0]);
        check("sat_eq", int'(eq2),     m_c2[1]);
        check("sat_lt", int'(lt2),     m_c2[2]);
        check("sat_res", int'(s_res),  int'(m_res));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic hold(input logic [2:0] v, input int n, inout int pulses);
        q = v;
        for (int i = 0; i < n; i++) begin
            step();
            #1;
            if (valid) pulses++;
        end
    endtask

    initial begin
        int p;
        int len;
        logic [2:0] v;

        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_res",   int'(res),   0);
        check("rst_valid", int'(valid), 0);
        check("rst_err",   int'(err),   0);
        check("rst_cnt",   int'(gt8) + int'(eq8) + int'(lt8), 0);

        // First commit lands exactly on edge L.
        q = 3'b010;
        for (int k = 1; k <= L; k++) begin
            step();
            #1;
            check("first_valid_edge", int'(valid), (k == L) ? 1 : 0);
        end
        check("first_res", int'(res), 3'b010);
        check("first_eq",  int'(eq8), 1);
        check("first_gtlt", int'(gt8) + int'(lt8), 0);
        check("first_err", int'(err), 0);

        // Short glitch returning to the committed value is invisible.
        p = 0;
        hold(3'b100, 2, p);
        hold(3'b010, 15, p);
        check("glitch_pulses", p, 0);
        check("glitch_res",    int'(res), 3'b010);
        check("glitch_gt",     int'(gt8), 0);

        // 100 -> 001 -> 100.
        p = 0;
        hold(3'b100, 10, p);
        hold(3'b001, 10, p);
        hold(3'b100, 10, p);
        check("three_pulses", p, 3);
        check("three_gt",     int'(gt8), 2);
        check("three_lt",     int'(lt8), 1);
        check("three_res",    int'(res), 3'b100);

        // Non-one-hot stable value raises err only.
        p = 0;
        hold(3'b001, 10, p);
        check("pre_err_lt", int'(lt8), 2);
        p = 0;
        hold(3'b110, 10, p);
        check("err_set",    int'(err), 1);
        check("err_res",    int'(res), 3'b001);
        check("err_pulses", p, 0);
        p = 0;
        hold(3'b001, 10, p);
        check("recover_pulses", p, 1);
        check("recover_res",    int'(res), 3'b001);
        check("recover_err",    int'(err), 0);
        check("recover_lt",     int'(lt8), 3);

        // Saturation on the CW=2 instance.
        p = 0;
        for (int i = 0; i < 8; i++) begin
            hold(3'b100, 10, p);
            hold(3'b001, 10, p);
        end
        check("sat_gt3", int'(gt2), 3);
        check("sat_lt3", int'(lt2), 3);
        check("wide_gt", int'(gt8), 10);

        // Clear on the same edge as a commit of 010.
        q = 3'b010;
        for (int k = 1; k < L; k++) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        #1;
        check("clr_valid", int'(valid), 1);
        check("clr_res",   int'(res),   3'b010);
        check("clr_cnt",   int'(gt8) + int'(eq8) + int'(lt8) + int'(gt2) + int'(eq2) + int'(lt2), 0);

        // Reset in the middle of a settle window.
        q = 3'b100;
        for (int k = 0; k < DLY + 3; k++) step();
        rst = 1'b1;
        #1;
        check("mid_rst_res",   int'(res),   0);
        check("mid_rst_valid", int'(valid), 0);
        check("mid_rst_cnt",   int'(eq8) + int'(gt8) + int'(lt8), 0);
        step();
        rst = 1'b0;
        for (int k = 1; k <= L; k++) begin
            step();
            #1;
            check("post_rst_valid", int'(valid), (k == L) ? 1 : 0);
        end
        check("post_rst_res", int'(res), 3'b100);
        check("post_rst_gt",  int'(gt8), 1);

        // Randomized phase; the compare process checks every cycle.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(9) < 8) begin
                case ($urandom_range(2))
                    0:       v = 3'b100;
                    1:       v = 3'b010;
                    default: v = 3'b001;
                endcase
            end else begin
                v = 3'($urandom_range(7));
            end
            len = $urandom_range(12, 1);
            q = v;
            for (int i = 0; i < len; i++) begin
                clr = ($urandom_range(39) == 0);
                rst = ($urandom_range(299) == 0);
                step();
            end
            clr = 1'b0;
            rst = 1'b0;
        end
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
